// File: rtl/ifu_fetch_ysyx_24100029.sv
// Instruction fetch: owns the PC, one outstanding imem read, hands words to decode; 3 cycles/inst best case.
// Backpressure: stalls in REQ on imem_req_ready, in HOLD on inst_ready. Optional counters: IFU_PERF_CNT_EN.
module ifu_fetch_ysyx_24100029 #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    output logic        imem_rsp_ready,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  oprand,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_discard_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic        discard;
    logic [31:0] redirect_target;
    logic        rsp_fire;
    logic        drop;
    logic        fetch_fire;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign rsp_fire        = (state == WAIT) && imem_rsp_valid;
    // A response is stale if an earlier redirect marked it, or a redirect lands in the same cycle.
    assign drop            = rsp_fire && (discard || redirect_valid);
    assign fetch_fire      = (state == HOLD) && inst_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     state_nxt = imem_req_ready ? WAIT : REQ;
            WAIT:    if (imem_rsp_valid) state_nxt = drop ? REQ : HOLD;
            HOLD:    if (redirect_valid || fetch_fire) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        imem_rsp_ready = 1'b0;
        inst_valid     = 1'b0;
        case (state)
            REQ:     imem_req_valid = 1'b1;
            WAIT:    imem_rsp_ready = 1'b1;
            HOLD:    inst_valid     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            inst    <= 32'h0;
            inst_pc <= RESET_PC;
            discard <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                        if (imem_req_ready) discard <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect_valid) pc <= redirect_target;
                    if (imem_rsp_valid) begin
                        discard <= 1'b0;
                        if (!drop) begin
                            inst    <= imem_rsp_data;
                            inst_pc <= pc;
                        end
                    end else if (redirect_valid) begin
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid) pc <= redirect_target;
                    else if (fetch_fire) pc <= pc + 32'd4;
                end
                default: ;
            endcase
        end
    end

    assign imem_req_addr = pc;
    assign opcode        = inst[6:0];
    assign funct3        = inst[14:12];
    assign oprand        = inst[31:25];

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt   <= 32'h0;
            perf_discard_cnt <= 32'h0;
        end else begin
            if (fetch_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (drop) perf_discard_cnt <= perf_discard_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch_ysyx_24100029.sv
// Bench for ifu_fetch_ysyx_24100029: randomized memory/decode timing against a PC/stream model.
module tb_ifu_fetch_ysyx_24100029;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid, imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic [6:0]  opcode, oprand;
    logic [2:0]  funct3;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_discard_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc;
    int unsigned m_fetch, m_disc;

    ifu_fetch_ysyx_24100029 #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .opcode(opcode), .funct3(funct3), .oprand(oprand),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_discard_cnt(perf_discard_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic wait_req();
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (imem_req_valid !== 1'b1) begin
            errors++; $display("FAIL req_timeout: valid=%b required 1", imem_req_valid);
        end
    endtask

    // One complete fetch with the given memory/decode wait cycles; consume=0 stops while holding.
    task automatic fetch_one(input int rw, input int sw, input int dw, input bit consume, output int cyc);
        logic [31:0] a, d;
        int n = 0;
        cyc = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk); n++; cyc++;
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== m_pc) begin
            errors++; $display("FAIL req_addr: valid=%b addr=%h required 1/%h", imem_req_valid, imem_req_addr, m_pc);
        end
        a = m_pc;
        for (int i = 0; i < rw; i++) begin
            imem_req_ready = 1'b0; @(negedge clk); cyc++;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin
                errors++; $display("FAIL req_hold: valid=%b addr=%h required 1/%h", imem_req_valid, imem_req_addr, a);
            end
        end
        imem_req_ready = 1'b1; @(negedge clk); cyc++; imem_req_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL wait_state: req_valid=%b rsp_ready=%b required 0/1", imem_req_valid, imem_rsp_ready);
        end
        for (int i = 0; i < sw; i++) begin
            @(negedge clk); cyc++;
            checks++;
            if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL rsp_wait: inst_valid=%b req_valid=%b required 0/0", inst_valid, imem_req_valid);
            end
        end
        d = $urandom;
        imem_rsp_valid = 1'b1; imem_rsp_data = d; @(negedge clk); cyc++; imem_rsp_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== d || inst_pc !== a) begin
            errors++; $display("FAIL inst_out: valid=%b inst=%h pc=%h required 1/%h/%h", inst_valid, inst, inst_pc, d, a);
        end
        checks++;
        if (opcode !== d[6:0] || funct3 !== d[14:12] || oprand !== d[31:25]) begin
            errors++; $display("FAIL fields: op=%h f3=%h opr=%h required %h/%h/%h", opcode, funct3, oprand, d[6:0], d[14:12], d[31:25]);
        end
        for (int i = 0; i < dw; i++) begin
            inst_ready = 1'b0; @(negedge clk); cyc++;
            checks++;
            if (inst_valid !== 1'b1 || inst !== d || inst_pc !== a || imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL hold_stable: v=%b inst=%h pc=%h req=%b required 1/%h/%h/0", inst_valid, inst, inst_pc, imem_req_valid, d, a);
            end
        end
        if (consume) begin
            inst_ready = 1'b1; @(negedge clk); cyc++; inst_ready = 1'b0;
            m_pc = a + 32'd4;
            m_fetch++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || imem_rsp_ready !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== RESET_PC) begin
            errors++; $display("FAIL reset_vals: rv=%b rr=%b iv=%b inst=%h pc=%h required 0/0/0/0/%h", imem_req_valid, imem_rsp_ready, inst_valid, inst, inst_pc, RESET_PC);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            errors++; $display("FAIL first_req: valid=%b addr=%h required 1/%h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        m_pc = RESET_PC; m_fetch = 0; m_disc = 0;
    endtask

    task automatic test_stream();
        int cyc;
        for (int i = 0; i < 3; i++) begin
            fetch_one(0, 0, 0, 1'b1, cyc);
            checks++;
            if (cyc != 3) begin
                errors++; $display("FAIL cadence: cycles=%0d required 3", cyc);
            end
        end
        for (int i = 0; i < 8; i++)
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, cyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        fetch_one(0, 0, 5, 1'b1, cyc);
        wait_req();
        checks++;
        if (imem_req_addr !== inst_pc + 32'd4) begin
            errors++; $display("FAIL bp_next: addr=%h required %h", imem_req_addr, inst_pc + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        bit same = 1'($urandom_range(0, 1));
        wait_req();
        imem_req_ready = 1'b1; @(negedge clk); imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        if (same) begin imem_rsp_valid = 1'b1; imem_rsp_data = $urandom; end
        @(negedge clk);
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        if (!same) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            checks++;
            if (imem_rsp_ready !== 1'b1 || inst_valid !== 1'b0) begin
                errors++; $display("FAIL rw_wait: rsp_ready=%b inst_valid=%b required 1/0", imem_rsp_ready, inst_valid);
            end
            imem_rsp_valid = 1'b1; imem_rsp_data = $urandom; @(negedge clk); imem_rsp_valid = 1'b0;
        end
        m_pc = 32'h8000_0100; m_disc++;
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== m_pc) begin
            errors++; $display("FAIL rw_drop: iv=%b rv=%b addr=%h required 0/1/%h", inst_valid, imem_req_valid, imem_req_addr, m_pc);
        end
`ifdef IFU_PERF_CNT_EN
        checks++;
        if (perf_discard_cnt !== m_disc) begin
            errors++; $display("FAIL perf_disc: got %0d required %0d", perf_discard_cnt, m_disc);
        end
`endif
    endtask

    task automatic test_redirect_req_fire();
        wait_req();
        imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0403;
        @(negedge clk);
        imem_req_ready = 1'b0; redirect_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        checks++;
        if (imem_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL rq_wait: rsp_ready=%b required 1", imem_rsp_ready);
        end
        imem_rsp_valid = 1'b1; imem_rsp_data = $urandom; @(negedge clk); imem_rsp_valid = 1'b0;
        m_pc = 32'h8000_0400; m_disc++;
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== m_pc) begin
            errors++; $display("FAIL rq_drop: iv=%b rv=%b addr=%h required 0/1/%h", inst_valid, imem_req_valid, imem_req_addr, m_pc);
        end
    endtask

    task automatic test_redirect_hold();
        int cyc;
        logic [31:0] tgt;
        for (int k = 0; k < 2; k++) begin
            fetch_one(0, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, cyc);
            tgt = (k == 0) ? 32'h8000_0200 : 32'h8000_0284;
            redirect_valid = 1'b1; redirect_pc = tgt; inst_ready = (k == 0);
            @(negedge clk);
            redirect_valid = 1'b0; inst_ready = 1'b0;
            if (k == 0) m_fetch++;
            m_pc = tgt;
            checks++;
            if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== tgt) begin
                errors++; $display("FAIL rh_next: iv=%b rv=%b addr=%h required 0/1/%h", inst_valid, imem_req_valid, imem_req_addr, tgt);
            end
        end
`ifdef IFU_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== m_fetch) begin
            errors++; $display("FAIL perf_fetch: got %0d required %0d", perf_fetch_cnt, m_fetch);
        end
`endif
    endtask

    task automatic test_req_stall();
        int cyc;
        logic [31:0] a, exp_a;
        wait_req();
        a = m_pc;
        for (int c = 1; c <= 4; c++) begin
            exp_a = (c >= 3) ? 32'h8000_0300 : a;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_a) begin
                errors++; $display("FAIL stall_c%0d: valid=%b addr=%h required 1/%h", c, imem_req_valid, imem_req_addr, exp_a);
            end
            imem_req_ready = 1'b0; redirect_valid = (c == 2); redirect_pc = 32'h8000_0300;
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        m_pc = 32'h8000_0300;
        fetch_one(0, 0, 0, 1'b1, cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        wait_req();
        imem_req_ready = 1'b1; @(negedge clk); imem_req_ready = 1'b0;
        checks++;
        if (imem_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL rm_wait: rsp_ready=%b required 1", imem_rsp_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_rsp_ready !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== RESET_PC || imem_req_addr !== RESET_PC) begin
            errors++; $display("FAIL rm_async: rv=%b rr=%b iv=%b inst=%h pc=%h addr=%h", imem_req_valid, imem_rsp_ready, inst_valid, inst, inst_pc, imem_req_addr);
        end
`ifdef IFU_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== 32'h0 || perf_discard_cnt !== 32'h0) begin
            errors++; $display("FAIL rm_perf: %0d/%0d required 0/0", perf_fetch_cnt, perf_discard_cnt);
        end
`endif
        @(negedge clk);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++;
        if (imem_rsp_ready !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0) begin
            errors++; $display("FAIL rm_idle_rsp: rr=%b iv=%b inst=%h required 0/0/0", imem_rsp_ready, inst_valid, inst);
        end
        rst_n = 1'b1;
        @(negedge clk);
        m_pc = RESET_PC; m_fetch = 0; m_disc = 0;
        fetch_one(1, 1, 1, 1'b1, cyc);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_req_fire();
        test_redirect_hold();
        test_req_stall();
        test_reset_mid();
`ifdef IFU_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== m_fetch || perf_discard_cnt !== m_disc) begin
            errors++; $display("FAIL perf_final: %0d/%0d required %0d/%0d", perf_fetch_cnt, perf_discard_cnt, m_fetch, m_disc);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifu_fetch_ysyx_24100029.md
# ifu_fetch_ysyx_24100029

Instruction fetch unit for the single-issue NPC core. It owns the PC, issues one word-aligned read at a time to instruction memory over a valid/ready request/response pair, and hands each fetched word to the decode stage through a valid/ready handshake. It slices out `opcode`/`funct3`/`oprand` for the control decoder. It accepts PC redirects from jump/branch resolution and discards any in-flight stale fetch.

## Interface
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  fetch address, bits[1:0] always 0.
- `imem_rsp_valid`  in  1  read data valid.
- `imem_rsp_ready`  out  1  IFU accepts response.
- `imem_rsp_data`  in  32  fetched word.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode consumes instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  PC of `inst`.
- `opcode`  out  7  `inst[6:0]`.
- `funct3`  out  3  `inst[14:12]`.
- `oprand`  out  7  `inst[31:25]`.
- `redirect_valid`  in  1  jump/branch taken, load new PC.
- `redirect_pc`  in  32  target; bits[1:0] are cleared on load.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Registers: `pc`, `inst`, `discard`.
- IDLE: all outputs deasserted. Advances to REQ on the first clock edge with `rst_n` high.
- REQ: `imem_req_valid`=1 and `imem_req_addr`=`pc`. When `imem_req_ready` is seen, go to WAIT.
- WAIT: `imem_rsp_ready`=1. When `imem_rsp_valid` is seen:
  - if `discard`=0: latch `inst`=`imem_rsp_data` and `inst_pc`=`pc`, then go to HOLD;
  - otherwise drop the data, clear `discard`, and go to REQ.
- HOLD: `inst_valid`=1. When `inst_ready` is seen, `pc`<=`pc`+4 (wraps modulo 2^32), then go to REQ.
- Only one request is outstanding at a time.
- Redirect rules (a redirect always overrides `pc`+4):
  - REQ without a handshake: `pc`<=target. The address changes on the next cycle while valid stays high; this is the only permitted change of address while valid is held.
  - REQ with a handshake in the same cycle: `pc`<=target, `discard`<=1, go to WAIT.
  - WAIT: `pc`<=target and `discard`<=1. If the response arrives in the same cycle, it is dropped immediately and the FSM goes to REQ.
  - HOLD, with or without `inst_ready`: `pc`<=target, `inst_valid` drops on the next cycle, go to REQ.
- `opcode`, `funct3` and `oprand` are combinational slices of the registered `inst`.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `inst`=0, `discard`=0. All valid/ready outputs are 0. `inst_pc`=`RESET_PC`.
- First request is asserted one cycle after `rst_n` deasserts.
- Best-case throughput, with zero-wait memory and decode always ready:
  - request accepted at cycle N, response at N+1;
  - `inst_valid` at N+2, consumed at N+2;
  - next request at N+3, giving 3 cycles per instruction.
- `inst` and `inst_pc` are stable while `inst_valid`=1 and `inst_ready`=0.
- Reset asserted mid-operation: everything returns to reset values immediately. Responses arriving in IDLE are ignored (`imem_rsp_ready`=0).

## Configuration
- `IFU_PERF_CNT_EN`: when defined, adds two outputs:
  - `perf_fetch_cnt` (out, 32): increments on each `inst_valid`&&`inst_ready` handshake.
  - `perf_discard_cnt` (out, 32): increments on each dropped response.
  - Both reset to 0 and wrap at 2^32.
- When undefined, the ports and counters do not exist and fetch behaviour is identical.

## Test plan
- Reset release, memory ready with 1-cycle response, decode always ready:
  - first request addr 0x8000_0000, then 0x8000_0004, 0x8000_0008;
  - `inst_valid` pulses every 3 cycles;
  - `opcode` equals `imem_rsp_data[6:0]`.
- Decode backpressure: hold `inst_ready`=0 for 5 cycles in HOLD.
  - `inst`/`inst_pc` stay stable and no new request is issued.
  - After release, next addr = `inst_pc`+4.
- Redirect in WAIT to 0x8000_0102:
  - the pending response is dropped, with no `inst_valid`;
  - next request addr 0x8000_0100;
  - `perf_discard_cnt`=1 with the macro defined.
- Redirect 0x8000_0200 coinciding with `inst_ready` in HOLD:
  - the instruction is consumed;
  - next request addr is 0x8000_0200, not `pc`+4.
- `imem_req_ready` held low for 4 cycles, with a redirect to 0x8000_0300 in cycle 2:
  - `imem_req_valid` stays high throughout;
  - addr changes to 0x8000_0300 in cycle 3;
  - the accepted request uses 0x8000_0300.
- Assert `rst_n` low during WAIT:
  - outputs immediately return to reset values;
  - a response pulse during IDLE is ignored;
  - fetch restarts at `RESET_PC`.
